// File: rtl/kgp_ctrl_pkg.sv
// Shared KGP-RISC control definitions: opcodes, ALUOp classes, FSM states and
// the decoded-opcode record passed from opcode_decode to the control FSM.
package kgp_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_ADDI     = 6'b000001;
    localparam logic [5:0] OP_SUBI     = 6'b000010;
    localparam logic [5:0] OP_ANDI     = 6'b000011;
    localparam logic [5:0] OP_ORI      = 6'b000100;
    localparam logic [5:0] OP_XORI     = 6'b000101;
    localparam logic [5:0] OP_SLAI     = 6'b000110;
    localparam logic [5:0] OP_SRAI     = 6'b000111;
    localparam logic [5:0] OP_SRLI     = 6'b001000;
    localparam logic [5:0] OP_LD       = 6'b001001;
    localparam logic [5:0] OP_ST       = 6'b001010;
    localparam logic [5:0] OP_MOVE     = 6'b001011;
    localparam logic [5:0] OP_J        = 6'b001100;
    localparam logic [5:0] OP_BR_FIRST = 6'b001101;
    localparam logic [5:0] OP_BR_LAST  = 6'b010000;
    localparam logic [5:0] OP_HALT     = 6'b111111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_SLA   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_MEM   = 4'b1010;
    localparam logic [3:0] ALU_BR    = 4'b1011;
    localparam logic [3:0] ALU_MOVE  = 4'b1100;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alu_src;
        logic       rtype;
        logic       imm;
        logic       ld;
        logic       st;
        logic       br;
        logic       jmp;
        logic       halt;
        logic       illegal;
    } op_class_t;

    localparam op_class_t CLASS_NONE    = op_class_t'(13'h0000);
    localparam op_class_t CLASS_ILLEGAL = op_class_t'(13'h0001);

    function automatic op_class_t imm_class(input logic [3:0] aluop);
        op_class_t c;
        c         = CLASS_NONE;
        c.aluop   = aluop;
        c.alu_src = 1'b1;
        c.imm     = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: ALUOp class, B-operand select and type flags.
module opcode_decode
    import kgp_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = CLASS_NONE;
        case (opcode)
            OP_RTYPE: begin
                cls.aluop = ALU_RTYPE;
                cls.rtype = 1'b1;
            end
            OP_ADDI: cls = imm_class(ALU_ADD);
            OP_SUBI: cls = imm_class(ALU_SUB);
            OP_ANDI: cls = imm_class(ALU_AND);
            OP_ORI:  cls = imm_class(ALU_OR);
            OP_XORI: cls = imm_class(ALU_XOR);
            OP_SLAI: cls = imm_class(ALU_SLA);
            OP_SRAI: cls = imm_class(ALU_SRA);
            OP_SRLI: cls = imm_class(ALU_SRL);
            OP_LD: begin
                cls.aluop   = ALU_MEM;
                cls.alu_src = 1'b1;
                cls.ld      = 1'b1;
            end
            OP_ST: begin
                cls.aluop   = ALU_MEM;
                cls.alu_src = 1'b1;
                cls.st      = 1'b1;
            end
            OP_MOVE: begin
                cls.aluop   = ALU_MOVE;
                cls.alu_src = 1'b1;
            end
            OP_J:    cls.jmp  = 1'b1;
            OP_HALT: cls.halt = 1'b1;
            default: begin
                if (opcode >= OP_BR_FIRST && opcode <= OP_BR_LAST) begin
                    cls.aluop = ALU_BR;
                    cls.br    = 1'b1;
                end else begin
                    cls = CLASS_ILLEGAL;
                end
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// KGP-RISC multi-cycle main control: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing
// with registered Moore outputs plus the few decisions that must act this cycle.
module control_fsm
    import kgp_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] ALUOp,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic       halted
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    op_class_t  dec;
    op_class_t  cls;
    logic [7:0] wait_cnt;
    logic       pc_write_q;
    logic       done_q;
    logic       timeout;

    opcode_decode u_opcode_decode (
        .opcode (opcode),
        .cls    (dec)
    );

    // Input-dependent decisions (branch taken, illegal opcode, memory handshake)
    // must show in the same cycle, so they bypass the output registers.
    assign timeout    = (state == S_MEM) && !mem_ready && (wait_cnt == TIMEOUT_CNT);
    assign mem_err    = timeout;
    assign illegal_op = (state == S_DECODE) && dec.illegal;
    assign pc_write   = pc_write_q || ((state == S_EXEC) && cls.br && alu_zero);
    assign instr_done = done_q || illegal_op || timeout ||
                        ((state == S_MEM) && cls.st && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            cls        <= CLASS_ILLEGAL;
            wait_cnt   <= '0;
            ALUOp      <= '0;
            ir_write   <= 1'b0;
            pc_write_q <= 1'b0;
            pc_src     <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            done_q     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            ALUOp      <= '0;
            ir_write   <= 1'b0;
            pc_write_q <= 1'b0;
            pc_src     <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                S_FETCH: begin
                    // Reset parks in FETCH with enables low; the first edge arms them.
                    if (ir_write) begin
                        state <= S_DECODE;
                    end else begin
                        ir_write   <= 1'b1;
                        pc_write_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    cls <= dec;
                    if (dec.illegal) begin
                        state      <= S_FETCH;
                        ir_write   <= 1'b1;
                        pc_write_q <= 1'b1;
                    end else if (dec.halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state      <= S_EXEC;
                        ALUOp      <= dec.aluop;
                        alu_src    <= dec.alu_src;
                        pc_src     <= dec.br || dec.jmp;
                        pc_write_q <= dec.jmp;
                        done_q     <= dec.br || dec.jmp;
                    end
                end
                S_EXEC: begin
                    if (cls.ld || cls.st) begin
                        state     <= S_MEM;
                        wait_cnt  <= '0;
                        ALUOp     <= ALU_MEM;
                        mem_read  <= cls.ld;
                        mem_write <= cls.st;
                    end else if ((cls.rtype || cls.imm || cls.alu_src) &&
                                 !cls.halt && !cls.illegal) begin
                        state     <= S_WB;
                        ALUOp     <= cls.aluop;
                        alu_src   <= cls.alu_src;
                        reg_write <= 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        state      <= S_FETCH;
                        ir_write   <= 1'b1;
                        pc_write_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ready && cls.ld) begin
                        state      <= S_WB;
                        ALUOp      <= cls.aluop;
                        alu_src    <= cls.alu_src;
                        reg_write  <= 1'b1;
                        mem_to_reg <= 1'b1;
                        done_q     <= 1'b1;
                    end else if (mem_ready || timeout) begin
                        state      <= S_FETCH;
                        ir_write   <= 1'b1;
                        pc_write_q <= 1'b1;
                    end else begin
                        ALUOp     <= ALU_MEM;
                        mem_read  <= cls.ld;
                        mem_write <= cls.st;
                        if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                S_WB: begin
                    state      <= S_FETCH;
                    ir_write   <= 1'b1;
                    pc_write_q <= 1'b1;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed scoreboard bench for control_fsm: per-cycle stimulus and expected
// output vectors are queued up front, then replayed and compared cycle by cycle.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] ALUOp;
    logic       ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg;
    logic       mem_read, mem_write, instr_done, illegal_op, mem_err, halted;

    control_fsm #(.MEM_TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .ALUOp      (ALUOp),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .mem_err    (mem_err),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // {ALUOp, ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg,
    //  mem_read, mem_write, instr_done, illegal_op, mem_err, halted}
    logic [15:0] obs;
    assign obs = {ALUOp, ir_write, pc_write, pc_src, alu_src, reg_write, mem_to_reg,
                  mem_read, mem_write, instr_done, illegal_op, mem_err, halted};

    localparam logic [15:0] IRW  = 16'h0800;
    localparam logic [15:0] PCW  = 16'h0400;
    localparam logic [15:0] PCS  = 16'h0200;
    localparam logic [15:0] ASRC = 16'h0100;
    localparam logic [15:0] RW   = 16'h0080;
    localparam logic [15:0] M2R  = 16'h0040;
    localparam logic [15:0] MRD  = 16'h0020;
    localparam logic [15:0] MWR  = 16'h0010;
    localparam logic [15:0] DONE = 16'h0008;
    localparam logic [15:0] ILL  = 16'h0004;
    localparam logic [15:0] MERR = 16'h0002;
    localparam logic [15:0] HLT  = 16'h0001;
    localparam logic [15:0] ALL  = 16'hFFFF;
    localparam logic [15:0] WBC  = 16'h0EFF;  // ALUOp/alu_src are unused in WB
    localparam logic [15:0] JC   = 16'hFEFF;  // alu_src is unused for J

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
        logic [15:0] care;
    } cyc_t;

    cyc_t sb[$];

    function automatic logic [15:0] alu(input logic [3:0] a);
        return {a, 12'h000};
    endfunction

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp, input logic [15:0] care);
        checks++;
        assert ((got & care) === (exp & care))
        else begin
            errors++;
            $error("FAIL %s: got %04h want %04h (care %04h)", tag, got, exp, care);
        end
    endtask

    task automatic push(input string tag, input logic [5:0] op, input logic z,
                        input logic rdy, input logic [15:0] exp,
                        input logic [15:0] care = ALL);
        cyc_t c;
        c.tag = tag; c.op = op; c.z = z; c.rdy = rdy; c.exp = exp; c.care = care;
        sb.push_back(c);
    endtask

    // Opcode and mem_ready are deliberately junk in FETCH: both must be ignored.
    task automatic fetch(input string tag);
        push({tag, ".F"}, 6'b111010, 1'b1, 1'b1, IRW | PCW);
    endtask

    task automatic alu_instr(input string tag, input logic [5:0] op,
                             input logic [3:0] cls, input logic src);
        fetch(tag);
        push({tag, ".D"}, op, 1'b0, 1'b0, '0);
        push({tag, ".E"}, 6'b000000, 1'b1, 1'b1, alu(cls) | (src ? ASRC : 16'h0));
        push({tag, ".W"}, 6'b000000, 1'b0, 1'b0, RW | DONE, WBC);
    endtask

    task automatic mem_instr(input string tag, input logic ld, input int waits,
                             input logic to);
        logic [15:0] req;
        req = alu(4'b1010) | (ld ? MRD : MWR);
        fetch(tag);
        push({tag, ".D"}, ld ? 6'b001001 : 6'b001010, 1'b0, 1'b0, '0);
        push({tag, ".E"}, 6'b000000, 1'b0, 1'b1, alu(4'b1010) | ASRC);
        for (int i = 0; i < waits; i++)
            push($sformatf("%s.M%0d", tag, i), 6'b000000, 1'b0, 1'b0, req);
        if (to)
            push({tag, ".Mto"}, 6'b000000, 1'b0, 1'b0, req | MERR | DONE);
        else if (ld) begin
            push({tag, ".Mrdy"}, 6'b000000, 1'b0, 1'b1, req);
            push({tag, ".W"}, 6'b000000, 1'b0, 1'b0, RW | M2R | DONE, WBC);
        end else
            push({tag, ".Mrdy"}, 6'b000000, 1'b0, 1'b1, req | DONE);
    endtask

    task automatic br_instr(input string tag, input logic [5:0] op, input logic z);
        fetch(tag);
        push({tag, ".D"}, op, 1'b0, 1'b0, '0);
        push({tag, ".E"}, 6'b000000, z, 1'b0, alu(4'b1011) | PCS | DONE | (z ? PCW : 16'h0));
    endtask

    task automatic run();
        cyc_t c;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            opcode = c.op; alu_zero = c.z; mem_ready = c.rdy;
            #1;
            check(c.tag, obs, c.exp, c.care);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got running want finished");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b1;
        opcode    = 6'b001010;
        repeat (3) @(negedge clk);
        #1 check("reset", obs, '0, ALL);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;

        alu_instr("addi",  6'b000001, 4'b0000, 1'b1);
        alu_instr("subi",  6'b000010, 4'b0001, 1'b1);
        alu_instr("rtype", 6'b000000, 4'b0010, 1'b0);
        alu_instr("andi",  6'b000011, 4'b0100, 1'b1);
        alu_instr("ori",   6'b000100, 4'b0101, 1'b1);
        alu_instr("xori",  6'b000101, 4'b0110, 1'b1);
        alu_instr("slai",  6'b000110, 4'b0111, 1'b1);
        alu_instr("srai",  6'b000111, 4'b1000, 1'b1);
        alu_instr("srli",  6'b001000, 4'b1001, 1'b1);
        alu_instr("move",  6'b001011, 4'b1100, 1'b1);
        mem_instr("ld3", 1'b1, 3, 1'b0);
        mem_instr("ld0", 1'b1, 0, 1'b0);
        mem_instr("st0", 1'b0, 0, 1'b0);
        mem_instr("st2", 1'b0, 2, 1'b0);
        br_instr("beq_t", 6'b001101, 1'b1);
        br_instr("beq_n", 6'b001101, 1'b0);
        br_instr("blast_t", 6'b010000, 1'b1);
        fetch("j");
        push("j.D", 6'b001100, 1'b0, 1'b0, '0);
        push("j.E", 6'b000000, 1'b0, 1'b0, PCW | PCS | DONE, JC);
        fetch("ill");
        push("ill.D", 6'b111010, 1'b0, 1'b0, ILL | DONE);
        fetch("ill2");
        push("ill2.D", 6'b010001, 1'b0, 1'b0, ILL | DONE);
        mem_instr("st_to", 1'b0, 255, 1'b1);
        alu_instr("after_to", 6'b000001, 4'b0000, 1'b1);
        fetch("st_rst");
        push("st_rst.D", 6'b001010, 1'b0, 1'b0, '0);
        push("st_rst.E", 6'b000000, 1'b0, 1'b0, alu(4'b1010) | ASRC);
        for (int i = 0; i < 3; i++)
            push($sformatf("st_rst.M%0d", i), 6'b000000, 1'b0, 1'b0, alu(4'b1010) | MWR);
        run();

        // Mid-cycle reset: request must drop before any clock edge.
        #1 rst = 1'b1;
        #1 check("rst_mid_mem", obs, '0, ALL);
        @(negedge clk);
        rst = 1'b0;
        alu_instr("post_rst", 6'b000011, 4'b0100, 1'b1);
        fetch("halt");
        push("halt.D", 6'b111111, 1'b0, 1'b0, '0);
        for (int i = 0; i < 22; i++)
            push($sformatf("halt.H%0d", i), 6'($urandom_range(0, 63)), 1'b1, 1'(i % 2), HLT);
        run();

        @(negedge clk);
        rst = 1'b1;
        #1 check("halt_rst", obs, '0, ALL);
        @(negedge clk);
        rst = 1'b0;
        alu_instr("after_halt", 6'b000001, 4'b0000, 1'b1);
        run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle main control unit for the KGP-RISC datapath, one stage upstream of the ALU control decoder. It sequences each instruction through fetch, decode, execute, memory and write-back, and drives the 4-bit `ALUOp` that the ALU control decoder turns into `ALUFn`. It also generates the PC, IR, register-file and data-memory enables, and handles a wait-state handshake with data memory.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum wait cycles in MEM before `mem_err` is raised and the FSM aborts to FETCH.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: `instruction[31:26]` from the IR; sampled in DECODE.
- `alu_zero` input 1: ALU Z flag; sampled in EXEC for branches.
- `mem_ready` input 1: data memory completes the access this cycle.
- `ALUOp` output 4: ALU operation class to the ALU control decoder.
- `ir_write` output 1: load the IR.
- `pc_write` output 1: load the PC.
- `pc_src` output 1: PC source select; 0 = PC+4, 1 = branch/jump target.
- `alu_src` output 1: ALU B operand select; 0 = register, 1 = sign-extended immediate.
- `reg_write` output 1: register-file write enable.
- `mem_to_reg` output 1: write-back source select; 1 = memory data.
- `mem_read` output 1: data-memory read request.
- `mem_write` output 1: data-memory write request.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `illegal_op` output 1: one-cycle pulse on an undefined opcode.
- `mem_err` output 1: one-cycle pulse on a memory timeout.
- `halted` output 1: high while in HALT.

## Operation
States: FETCH, DECODE, EXEC, MEM, WB, HALT. All are Moore except where noted.

Opcode to `ALUOp` class mapping:
- 000000 R-type → 0010
- 000001 ADDI → 0000
- 000010 SUBI → 0001
- 000011 ANDI → 0100
- 000100 ORI → 0101
- 000101 XORI → 0110
- 000110 SLAI → 0111
- 000111 SRAI → 1000
- 001000 SRLI → 1001
- 001001 LD and 001010 ST → 1010
- 001011 MOVE → 1100
- 001100 J → none
- 001101–010000 branches → 1011
- 111111 HALT
- Any other opcode is illegal.

State behaviour:
- **FETCH**: assert `ir_write` and `pc_write` with `pc_src`=0. Next state DECODE.
- **DECODE**: latch the `opcode` class into an internal register.
  - Illegal opcode: pulse `illegal_op` and `instr_done`, go to FETCH.
  - HALT opcode: go to HALT.
  - Otherwise: go to EXEC.
- **EXEC**: drive `ALUOp` from the latched class. `alu_src`=1 for immediates, LD/ST and MOVE; 0 for R-type and branches.
  - Branch: `pc_write` = `alu_zero` (Mealy), `pc_src`=1, pulse `instr_done`, go to FETCH.
  - J: `pc_write`=1, `pc_src`=1, `instr_done`, go to FETCH.
  - LD/ST: go to MEM.
  - All others: go to WB.
- **MEM**: hold `ALUOp`=1010, and hold `mem_read` (LD) or `mem_write` (ST) until `mem_ready`.
  - LD on `mem_ready`: go to WB.
  - ST on `mem_ready`: pulse `instr_done`, go to FETCH.
  - After `MEM_TIMEOUT` cycles without `mem_ready`: pulse `mem_err` and `instr_done`, drop the request, go to FETCH.
  - The wait counter is 8 bits and saturates. It clears on entry to MEM.
- **WB**: pulse `reg_write` and `instr_done`; `mem_to_reg`=1 only for LD. Go to FETCH.
- **HALT**: all enables 0, `halted`=1. Only `rst` exits.

When not in EXEC, MEM or WB, `ALUOp` is 0000.

## Timing
- Reset values (asynchronous): state=FETCH, all enables 0, `ALUOp`=0000, pulse outputs 0, `halted`=0, latched class = illegal.
  - The first FETCH occurs on the first edge after `rst` deasserts.
- Latency per instruction:
  - ALU, MOVE and R-type: 4 cycles.
  - LD: 5 + wait cycles.
  - ST: 4 + wait cycles.
  - Branch and J: 3 cycles.
  - Illegal: 2 cycles.
- `mem_ready` asserted in the first MEM cycle means zero wait cycles. `mem_ready` outside MEM is ignored.
- `rst` asserted mid-MEM drops `mem_read`/`mem_write` immediately, with no edge required.
- `opcode` is don't-care outside DECODE.
- `instr_done` is exactly one pulse per retired instruction and is never asserted in HALT.

## Structure
- Shared package `kgp_ctrl_pkg` holds:
  - opcode constants;
  - `ALUOp` class constants, matching the ALU control decoder encodings;
  - the state enum;
  - `MEM_TIMEOUT` default.
- Sub-module `opcode_decode` (combinational) maps `opcode` to `ALUOp` class, `alu_src` and type flags (rtype, imm, ld, st, br, jmp, halt, illegal). It is reused by the hazard unit later.

## Test plan
- **ADDI**: `opcode`=000001 after reset. Expect `ALUOp`=0000 and `alu_src`=1 in EXEC, `reg_write` on cycle 4, then `instr_done`.
- **LD with waits**: `opcode`=001001, `mem_ready` low for 3 cycles. Expect `mem_read` high for 4 cycles, then WB with `mem_to_reg`=1; 8 cycles total.
- **Branch**: `opcode`=001101.
  - `alu_zero`=1: `pc_write`=1 and `pc_src`=1 in EXEC.
  - `alu_zero`=0: `pc_write`=0.
  - Both cases retire in 3 cycles.
- **Illegal and HALT**: `opcode`=111010 pulses `illegal_op` and returns to FETCH. `opcode`=111111 holds `halted`=1 for 20+ cycles with no enables until `rst`.
- **Timeout and reset**: ST with `mem_ready` never asserted pulses `mem_err` after 255 cycles. A repeat with `rst` raised mid-MEM drops `mem_write` asynchronously, and state returns to FETCH.
